// File: rtl/interrupt_ack_arbiter_if.sv
// CPU-side acknowledge bus: INTA strobe in, INT request and vector level out.
interface interrupt_ack_arbiter_if;
    logic       interrupt_acknowledge_n;
    logic       interrupt_to_cpu;
    logic       vector_valid;
    logic [2:0] vector_level;

    modport master (
        output interrupt_acknowledge_n,
        input  interrupt_to_cpu,
        input  vector_valid,
        input  vector_level
    );

    modport slave (
        input  interrupt_acknowledge_n,
        output interrupt_to_cpu,
        output vector_valid,
        output vector_level
    );
endinterface

// File: rtl/interrupt_ack_arbiter.sv
// Rotating-priority arbiter, ISR keeper and two-pulse 8086 INTA sequencer for the PIC.
module interrupt_ack_arbiter #(
    parameter int NUM_IR      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 write_ICW1,
    input  logic [NUM_IR-1:0]    irr,
    input  logic [NUM_IR-1:0]    int_mask,
    input  logic [2:0]           priority_rotate,
    input  logic                 auto_eoi,
    input  logic [NUM_IR-1:0]    eoi,
    interrupt_ack_arbiter_if.slave bus,
    output logic [NUM_IR-1:0]    isr,
    output logic [NUM_IR-1:0]    clear_IRR,
    output logic                 ack_busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        ACK1  = 3'd2,
        ACK2W = 3'd3,
        ACK2  = 3'd4
    } state_t;

    state_t                  r_state;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    r_prev;
    logic [2:0]              r_lvl;
    logic                    r_spur;
    logic                    r_int;
    logic [NUM_IR-1:0]       r_isr;
    logic [NUM_IR-1:0]       r_clr;
    logic                    r_vv;
    logic [2:0]              r_vl;

    logic                    w_cur;
    logic                    w_fall;
    logic                    w_rise;
    logic [NUM_IR-1:0]       w_cand;
    logic [2:0]              w_win;
    logic [2:0]              w_top;
    logic                    w_req;
    logic [NUM_IR-1:0]       w_set;
    logic [NUM_IR-1:0]       w_aclr;
    logic [NUM_IR-1:0]       w_isr_next;

    // Rank 0 is the highest priority; level rot+1 gets rank 0, level rot gets rank 7.
    function automatic logic [2:0] rank_of(input logic [2:0] lvl, input logic [2:0] rot);
        return lvl - rot - 3'd1;
    endfunction

    // Walk from lowest to highest priority so the last hit is the winner.
    function automatic logic [2:0] top_of(input logic [NUM_IR-1:0] v, input logic [2:0] rot);
        logic [2:0] l;
        top_of = 3'd0;
        for (int k = NUM_IR - 1; k >= 0; k--) begin
            l = rot + 3'd1 + 3'(k);
            if (v[l]) top_of = l;
        end
    endfunction

    assign w_cur  = r_sync[SYNC_STAGES-1];
    assign w_fall = r_prev & ~w_cur;
    assign w_rise = ~r_prev & w_cur;

    assign w_cand = irr & ~int_mask;
    assign w_win  = top_of(w_cand, priority_rotate);
    assign w_top  = top_of(r_isr, priority_rotate);
    assign w_req  = (|w_cand) &&
                    ((r_isr == '0) ||
                     (rank_of(w_win, priority_rotate) < rank_of(w_top, priority_rotate)));

    // Set wins over a same-cycle clear; auto-EOI and external EOI clears are merged.
    always_comb begin
        w_set  = '0;
        w_aclr = '0;
        if (r_state == REQ && w_fall && (|w_cand))
            w_set[w_win] = 1'b1;
        if (r_state == ACK2 && w_rise && auto_eoi && !r_spur)
            w_aclr[r_lvl] = 1'b1;
        w_isr_next = (r_isr & ~(eoi | w_aclr)) | w_set;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_sync  <= '1;
            r_prev  <= 1'b1;
            r_lvl   <= 3'd0;
            r_spur  <= 1'b0;
            r_int   <= 1'b0;
            r_isr   <= '0;
            r_clr   <= '0;
            r_vv    <= 1'b0;
            r_vl    <= 3'd0;
        end else if (write_ICW1) begin
            r_state <= IDLE;
            r_sync  <= '1;
            r_prev  <= 1'b1;
            r_lvl   <= 3'd0;
            r_spur  <= 1'b0;
            r_int   <= 1'b0;
            r_isr   <= '0;
            r_clr   <= '0;
            r_vv    <= 1'b0;
            r_vl    <= 3'd0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.interrupt_acknowledge_n};
            r_prev <= w_cur;
            r_isr  <= w_isr_next;
            r_clr  <= '0;
            case (r_state)
                IDLE: begin
                    // An INTA with no INT outstanding is answered as spurious.
                    if (w_fall) begin
                        r_state <= ACK1;
                        r_lvl   <= 3'd7;
                        r_spur  <= 1'b1;
                    end else if (w_req) begin
                        r_state <= REQ;
                        r_int   <= 1'b1;
                    end
                end
                REQ: begin
                    if (w_fall) begin
                        r_int   <= 1'b0;
                        r_state <= ACK1;
                        if (|w_cand) begin
                            r_lvl  <= w_win;
                            r_spur <= 1'b0;
                            r_clr  <= w_set;
                        end else begin
                            r_lvl  <= 3'd7;
                            r_spur <= 1'b1;
                        end
                    end else if (!w_req) begin
                        r_int   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                ACK1: begin
                    if (w_rise) r_state <= ACK2W;
                end
                ACK2W: begin
                    if (w_fall) begin
                        r_state <= ACK2;
                        r_vv    <= 1'b1;
                        r_vl    <= r_lvl;
                    end
                end
                ACK2: begin
                    if (w_rise) begin
                        r_vv    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.interrupt_to_cpu = r_int;
    assign bus.vector_valid     = r_vv;
    assign bus.vector_level     = r_vl;
    assign isr                  = r_isr;
    assign clear_IRR            = r_clr;
    assign ack_busy             = (r_state != IDLE);

endmodule

// File: tb/tb_interrupt_ack_arbiter.sv
// Directed bench for interrupt_ack_arbiter: nesting, rotation, spurious, auto-EOI and reset cases.
module tb_interrupt_ack_arbiter;

    logic       clk;
    logic       reset_n;
    logic       write_ICW1;
    logic [7:0] irr;
    logic [7:0] int_mask;
    logic [2:0] priority_rotate;
    logic       auto_eoi;
    logic [7:0] eoi;
    logic [7:0] isr;
    logic [7:0] clear_IRR;
    logic       ack_busy;

    int total = 0;
    int bad   = 0;

    interrupt_ack_arbiter_if bus ();

    interrupt_ack_arbiter #(.NUM_IR(8), .SYNC_STAGES(2)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .write_ICW1      (write_ICW1),
        .irr             (irr),
        .int_mask        (int_mask),
        .priority_rotate (priority_rotate),
        .auto_eoi        (auto_eoi),
        .eoi             (eoi),
        .bus             (bus.slave),
        .isr             (isr),
        .clear_IRR       (clear_IRR),
        .ack_busy        (ack_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // First INTA pulse: records how many cycles clear_IRR was nonzero and its value.
    task automatic inta1(output int ncl, output logic [7:0] cl);
        ncl = 0;
        cl  = 8'h00;
        bus.interrupt_acknowledge_n = 1'b0;
        repeat (6) begin
            tick();
            if (clear_IRR != 8'h00) begin
                ncl++;
                cl = clear_IRR;
            end
        end
        bus.interrupt_acknowledge_n = 1'b1;
        repeat (6) tick();
    endtask

    // Second INTA pulse: samples the vector while low and vector_valid after the rise.
    task automatic inta2(output logic vv_low, output logic [2:0] vl_low, output logic vv_after);
        bus.interrupt_acknowledge_n = 1'b0;
        repeat (6) tick();
        vv_low = bus.vector_valid;
        vl_low = bus.vector_level;
        bus.interrupt_acknowledge_n = 1'b1;
        repeat (6) tick();
        vv_after = bus.vector_valid;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.interrupt_to_cpu !== 1'b0) begin bad++; $display("FAIL reset_int: got %b want 0", bus.interrupt_to_cpu); end
        total++; if (isr !== 8'h00) begin bad++; $display("FAIL reset_isr: got %h want 00", isr); end
        total++; if (bus.vector_valid !== 1'b0) begin bad++; $display("FAIL reset_vv: got %b want 0", bus.vector_valid); end
        total++; if (ack_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", ack_busy); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int ncl; logic [7:0] cl; logic vv, vva; logic [2:0] vl;
        priority_rotate = 3'd7; int_mask = 8'h00; auto_eoi = 1'b0;
        irr = 8'h08;
        total++; if (bus.interrupt_to_cpu !== 1'b0) begin bad++; $display("FAIL basic_int_early: got %b want 0", bus.interrupt_to_cpu); end
        tick();
        total++; if (bus.interrupt_to_cpu !== 1'b1) begin bad++; $display("FAIL basic_int: got %b want 1", bus.interrupt_to_cpu); end
        total++; if (ack_busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", ack_busy); end
        inta1(ncl, cl);
        irr = 8'h00;
        total++; if (ncl !== 1) begin bad++; $display("FAIL basic_clr_cycles: got %0d want 1", ncl); end
        total++; if (cl !== 8'h08) begin bad++; $display("FAIL basic_clr_val: got %h want 08", cl); end
        total++; if (isr !== 8'h08) begin bad++; $display("FAIL basic_isr1: got %h want 08", isr); end
        total++; if (bus.interrupt_to_cpu !== 1'b0) begin bad++; $display("FAIL basic_int_drop: got %b want 0", bus.interrupt_to_cpu); end
        inta2(vv, vl, vva);
        total++; if (vv !== 1'b1) begin bad++; $display("FAIL basic_vv: got %b want 1", vv); end
        total++; if (vl !== 3'd3) begin bad++; $display("FAIL basic_vl: got %0d want 3", vl); end
        total++; if (vva !== 1'b0) begin bad++; $display("FAIL basic_vv_after: got %b want 0", vva); end
        total++; if (isr !== 8'h08) begin bad++; $display("FAIL basic_isr2: got %h want 08", isr); end
        total++; if (ack_busy !== 1'b0) begin bad++; $display("FAIL basic_idle: got %b want 0", ack_busy); end
    endtask

    task automatic test_nested();
        int ncl; logic [7:0] cl; logic vv, vva; logic [2:0] vl;
        irr = 8'h20;
        repeat (3) tick();
        total++; if (bus.interrupt_to_cpu !== 1'b0) begin bad++; $display("FAIL nest_block: got %b want 0", bus.interrupt_to_cpu); end
        irr = 8'h02;
        tick();
        total++; if (bus.interrupt_to_cpu !== 1'b1) begin bad++; $display("FAIL nest_int: got %b want 1", bus.interrupt_to_cpu); end
        inta1(ncl, cl);
        irr = 8'h00;
        total++; if (cl !== 8'h02) begin bad++; $display("FAIL nest_clr: got %h want 02", cl); end
        inta2(vv, vl, vva);
        total++; if (vl !== 3'd1) begin bad++; $display("FAIL nest_vl: got %0d want 1", vl); end
        total++; if (isr !== 8'h0A) begin bad++; $display("FAIL nest_isr: got %h want 0a", isr); end
        eoi = 8'h02; tick(); eoi = 8'h00;
        total++; if (isr !== 8'h08) begin bad++; $display("FAIL nest_eoi: got %h want 08", isr); end
        eoi = 8'h08; tick(); eoi = 8'h00;
        total++; if (isr !== 8'h00) begin bad++; $display("FAIL nest_eoi2: got %h want 00", isr); end
    endtask

    task automatic test_rotation();
        int ncl; logic [7:0] cl; logic vv, vva; logic [2:0] vl;
        priority_rotate = 3'd3;
        irr = 8'h81;
        tick();
        total++; if (bus.interrupt_to_cpu !== 1'b1) begin bad++; $display("FAIL rot_int: got %b want 1", bus.interrupt_to_cpu); end
        inta1(ncl, cl);
        irr = 8'h01;
        total++; if (cl !== 8'h80) begin bad++; $display("FAIL rot_clr: got %h want 80", cl); end
        inta2(vv, vl, vva);
        total++; if (vl !== 3'd7) begin bad++; $display("FAIL rot_vl: got %0d want 7", vl); end
        total++; if (isr !== 8'h80) begin bad++; $display("FAIL rot_isr: got %h want 80", isr); end
        repeat (2) tick();
        total++; if (bus.interrupt_to_cpu !== 1'b0) begin bad++; $display("FAIL rot_ir0_blocked: got %b want 0", bus.interrupt_to_cpu); end
        irr = 8'h00;
        eoi = 8'h80; tick(); eoi = 8'h00;
        priority_rotate = 3'd7;
        tick();
    endtask

    task automatic test_spurious();
        int ncl; logic [7:0] cl; logic vv, vva; logic [2:0] vl;
        irr = 8'h10;
        tick();
        total++; if (bus.interrupt_to_cpu !== 1'b1) begin bad++; $display("FAIL spur_int: got %b want 1", bus.interrupt_to_cpu); end
        irr = 8'h00;
        tick();
        total++; if (bus.interrupt_to_cpu !== 1'b0) begin bad++; $display("FAIL spur_int_drop: got %b want 0", bus.interrupt_to_cpu); end
        inta1(ncl, cl);
        total++; if (ncl !== 0) begin bad++; $display("FAIL spur_clr: got %0d pulses want 0", ncl); end
        total++; if (ack_busy !== 1'b1) begin bad++; $display("FAIL spur_busy: got %b want 1", ack_busy); end
        inta2(vv, vl, vva);
        total++; if (vl !== 3'd7) begin bad++; $display("FAIL spur_vl: got %0d want 7", vl); end
        total++; if (isr !== 8'h00) begin bad++; $display("FAIL spur_isr: got %h want 00", isr); end
    endtask

    task automatic test_auto_eoi();
        int ncl; logic [7:0] cl; logic vv, vva; logic [2:0] vl;
        auto_eoi = 1'b1;
        irr = 8'h01;
        tick();
        inta1(ncl, cl);
        irr = 8'h00;
        total++; if (isr !== 8'h01) begin bad++; $display("FAIL aeoi_isr_set: got %h want 01", isr); end
        inta2(vv, vl, vva);
        total++; if (vl !== 3'd0) begin bad++; $display("FAIL aeoi_vl: got %0d want 0", vl); end
        total++; if (isr !== 8'h00) begin bad++; $display("FAIL aeoi_isr_clr: got %h want 00", isr); end
        // Set of bit 2 lands in the same clock as an external EOI of bit 2.
        irr = 8'h04;
        tick();
        bus.interrupt_acknowledge_n = 1'b0;
        tick(); tick();
        eoi = 8'h04;
        tick();
        eoi = 8'h00;
        total++; if (isr[2] !== 1'b1) begin bad++; $display("FAIL aeoi_set_wins: got %b want 1", isr[2]); end
        total++; if (clear_IRR !== 8'h04) begin bad++; $display("FAIL aeoi_clr: got %h want 04", clear_IRR); end
        irr = 8'h00;
        bus.interrupt_acknowledge_n = 1'b1;
        repeat (6) tick();
        inta2(vv, vl, vva);
        total++; if (vl !== 3'd2) begin bad++; $display("FAIL aeoi_vl2: got %0d want 2", vl); end
        total++; if (isr !== 8'h00) begin bad++; $display("FAIL aeoi_isr_end: got %h want 00", isr); end
        auto_eoi = 1'b0;
    endtask

    task automatic test_reset_mid();
        int ncl; logic [7:0] cl; logic vv, vva; logic [2:0] vl;
        irr = 8'h02;
        tick();
        inta1(ncl, cl);
        irr = 8'h00;
        total++; if (isr !== 8'h02) begin bad++; $display("FAIL mid_isr_pre: got %h want 02", isr); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (isr !== 8'h00) begin bad++; $display("FAIL mid_isr: got %h want 00", isr); end
        total++; if (ack_busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", ack_busy); end
        total++; if (bus.vector_level !== 3'd0) begin bad++; $display("FAIL mid_vl: got %0d want 0", bus.vector_level); end
        total++; if (clear_IRR !== 8'h00) begin bad++; $display("FAIL mid_clr: got %h want 00", clear_IRR); end
        #2 reset_n = 1'b1;
        tick();
        irr = 8'h04;
        tick();
        total++; if (bus.interrupt_to_cpu !== 1'b1) begin bad++; $display("FAIL mid_int: got %b want 1", bus.interrupt_to_cpu); end
        inta1(ncl, cl);
        irr = 8'h00;
        total++; if (cl !== 8'h04) begin bad++; $display("FAIL mid_first_pulse: got %h want 04", cl); end
        inta2(vv, vl, vva);
        total++; if (vl !== 3'd2) begin bad++; $display("FAIL mid_vl2: got %0d want 2", vl); end
        total++; if (isr !== 8'h04) begin bad++; $display("FAIL mid_isr2: got %h want 04", isr); end
    endtask

    task automatic test_icw1();
        irr = 8'h01;
        tick();
        total++; if (bus.interrupt_to_cpu !== 1'b1) begin bad++; $display("FAIL icw1_int: got %b want 1", bus.interrupt_to_cpu); end
        write_ICW1 = 1'b1;
        tick();
        write_ICW1 = 1'b0;
        irr = 8'h00;
        total++; if (isr !== 8'h00) begin bad++; $display("FAIL icw1_isr: got %h want 00", isr); end
        total++; if (bus.interrupt_to_cpu !== 1'b0) begin bad++; $display("FAIL icw1_int_clr: got %b want 0", bus.interrupt_to_cpu); end
        total++; if (ack_busy !== 1'b0) begin bad++; $display("FAIL icw1_busy: got %b want 0", ack_busy); end
    endtask

    initial begin
        reset_n = 1'b0; write_ICW1 = 1'b0; irr = 8'h00; int_mask = 8'h00;
        priority_rotate = 3'd7; auto_eoi = 1'b0; eoi = 8'h00;
        bus.interrupt_acknowledge_n = 1'b1;
        test_reset();
        test_basic();
        test_nested();
        test_rotation();
        test_spurious();
        test_auto_eoi();
        test_reset_mid();
        test_icw1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interrupt_ack_arbiter.md
Name: interrupt_ack_arbiter

Overview:
- Clocked priority arbiter and INTA sequencer for the PIC. It arbitrates eight IR requesters onto the single CPU interrupt line.
- Sits between the IRR/mask/rotate outputs of the control logic and the CPU-side INTA bus.
- Maintains the ISR, runs the two-pulse 8086 acknowledge sequence, pulses IRR clears and applies EOI clears.

Parameters:
- NUM_IR, 8, number of interrupt request lines. Fixed at 8; other values unsupported.
- SYNC_STAGES, 2, synchronizer flops on interrupt_acknowledge_n. Minimum 2.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- write_ICW1  input  1  synchronous re-initialise strobe, one clk.
- irr  input  8  interrupt request register contents.
- int_mask  input  8  1 = IR masked.
- priority_rotate  input  3  lowest-priority level. 7 = fully nested (IR0 highest).
- auto_eoi  input  1  clear ISR bit at end of acknowledge sequence.
- eoi  input  8  one-clk ISR clear mask.
- interrupt_acknowledge_n  input  1  CPU INTA, asynchronous, active low.
- interrupt_to_cpu  output  1  INT request to CPU.
- isr  output  8  in-service register.
- clear_IRR  output  8  one-clk one-hot clear to IRR.
- vector_valid  output  1  high while the vector level may be driven (second INTA low).
- vector_level  output  3  acknowledged level. 7 on a spurious acknowledge.
- ack_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All outputs 0. FSM goes to IDLE.
  - Synchronizer flops preset to 1, so there is no false edge after reset.
  - Reset mid-sequence abandons it; ISR is cleared.
- write_ICW1 (synchronous): same effect as reset on the next edge. Takes priority over all other events.
- INTA synchronizer:
  - interrupt_acknowledge_n passes through SYNC_STAGES flops, then one edge-detect flop.
  - fall = previous 1, current 0. rise = previous 0, current 1.
- Priority order:
  - Highest priority is level (priority_rotate+1) mod 8, descending cyclically to priority_rotate.
  - cand = irr & ~int_mask.
  - win = highest-priority set bit of cand.
  - isr_top = highest-priority set bit of isr.
- Request condition: cand != 0, and (isr == 0 or win has strictly higher priority than isr_top). This is fully nested; equal or lower levels are blocked.
- FSM states:
  - IDLE: if the request condition holds, go to REQ and register interrupt_to_cpu=1. Latency is 1 clk from cand change.
  - REQ:
    - interrupt_to_cpu stays 1.
    - If the request condition drops before fall, deassert and return to IDLE.
    - On fall: latch win into lvl, set isr[lvl], pulse clear_IRR=1<<lvl for one clk, deassert interrupt_to_cpu, go to ACK1.
    - If cand == 0 at fall (spurious): lvl=7, no ISR set, clear_IRR=0, spurious flag set.
  - ACK1: wait for rise, then go to ACK2W.
  - ACK2W: on fall, go to ACK2. vector_valid=1 and vector_level=lvl, registered.
  - ACK2:
    - vector_valid stays 1.
    - On rise: vector_valid=0. If auto_eoi and not spurious, clear isr[lvl]. Go to IDLE.
- The win level is frozen at the first fall. IRR changes during ACK1/ACK2 do not alter vector_level.
- EOI:
  - isr_next = (isr & ~eoi) | set_mask. Accepted in any state.
  - If set and clear hit the same bit in the same clk, set wins.
  - An auto-EOI clear and an external eoi in the same clk are OR-combined.
- Re-arm: from IDLE, a still-pending higher request reasserts interrupt_to_cpu on the clk after entering IDLE.
- fall seen in IDLE (INTA with no INT): treated as a spurious first pulse. Go to ACK1 with lvl=7.

Test Plan:
- Reset, then irr=0x08, mask=0x00, rotate=7: interrupt_to_cpu=1 one clk after irr.
  - First INTA gives isr=0x08 and a single-clk clear_IRR=0x08.
  - Second INTA gives vector_valid=1, vector_level=3. After the rise, isr stays 0x08 (auto_eoi=0).
- Nested blocking: with isr=0x08, irr=0x20 gives no INT. irr=0x02 gives INT and, after the sequence, isr=0x0A. Then eoi=0x02 gives isr=0x08.
- Rotation: rotate=3, irr=0x81. IR4 is highest, so IR7 wins: vector_level=7, isr=0x80.
- Spurious: INT asserted on irr=0x10, irr drops to 0 before the first INTA. If the sequence completes anyway, vector_level=7, isr=0x00, clear_IRR=0.
- auto_eoi=1, irr=0x01: after the second INTA rise, isr=0x00.
  - Concurrent eoi=0x04 with the set of bit 2 in another sequence leaves isr bit 2 = 1.
- reset_n low between the two INTA pulses: all outputs 0 immediately.
  - The next sequence restarts from IDLE, and the first INTA after reset is taken as the first pulse.
